exp_align: RTL and testbench

Exponent-alignment stage of the floating-point adder, directly downstream of the exponent `comparator`. It takes two operands' exponents and mantissas, plus the comparator's 2-bit result code. It selects the larger-exponent operand and right-shifts the smaller operand's mantissa by the exponent difference, one bit per cycle, collecting guard, round and sticky bits. It then presents the aligned pair to the mantissa adder over a valid/ready handshake.

---
 rtl/exp_align.sv | 141 ++++++++++++++
 tb/tb_exp_align.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/exp_align.sv
// Exponent-alignment stage: picks the larger-exponent operand and right-shifts the
// smaller mantissa one bit per cycle, keeping guard/round/sticky, then hands off via valid/ready.
//
// state | meaning
// IDLE  | waiting for an operand set; in_ready_o high
// SHIFT | sticky right-shifting the small mantissa, one bit per cycle
// DONE  | aligned result presented; held until out_ready_i
module exp_align #(
  parameter int EXP_SIZE = 8,
  parameter int MAN_SIZE = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [EXP_SIZE-1:0]   in_exp_a_i,
  input  logic [EXP_SIZE-1:0]   in_exp_b_i,
  input  logic [MAN_SIZE-1:0]   in_man_a_i,
  input  logic [MAN_SIZE-1:0]   in_man_b_i,
  input  logic [1:0]            in_code_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [EXP_SIZE-1:0]   out_exp_o,
  output logic [MAN_SIZE-1:0]   out_man_big_o,
  output logic [MAN_SIZE+2:0]   out_man_small_o,
  output logic                  out_swap_o,
  output logic                  out_error_o
);

  localparam int W = MAN_SIZE + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q;
  logic [EXP_SIZE-1:0] cnt_q;
  logic [EXP_SIZE-1:0] exp_q;
  logic [MAN_SIZE-1:0] man_big_q;
  logic [W-1:0]        small_q;
  logic                swap_q;
  logic                error_q;
  logic                valid_q;

  logic                code_err_d;
  logic                swap_d;
  logic [EXP_SIZE-1:0] big_exp_d;
  logic [EXP_SIZE-1:0] small_exp_d;
  logic [MAN_SIZE-1:0] big_man_d;
  logic [MAN_SIZE-1:0] small_man_d;
  logic [EXP_SIZE-1:0] dist_d;
  logic [W-1:0]        small_init_d;
  logic [W-1:0]        small_short_d;
  logic                short_d;

  always_comb begin
    code_err_d = 1'b0;
    unique case (in_code_i)
      2'b00:   code_err_d = (in_exp_a_i != in_exp_b_i);
      2'b01:   code_err_d = !(in_exp_a_i < in_exp_b_i);
      2'b10:   code_err_d = !(in_exp_a_i > in_exp_b_i);
      default: code_err_d = 1'b1;
    endcase
    // On error A/B pass through unswapped, so swap is only taken on a consistent 01.
    swap_d        = (in_code_i == 2'b01) && !code_err_d;
    big_exp_d     = swap_d ? in_exp_b_i : in_exp_a_i;
    small_exp_d   = swap_d ? in_exp_a_i : in_exp_b_i;
    big_man_d     = swap_d ? in_man_b_i : in_man_a_i;
    small_man_d   = swap_d ? in_man_a_i : in_man_b_i;
    dist_d        = big_exp_d - small_exp_d;
    small_init_d  = {small_man_d, 3'b000};
    small_short_d = {{(W-1){1'b0}}, |small_man_d};
    short_d       = (int'(dist_d) >= MAN_SIZE + 2);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      exp_q     <= '0;
      man_big_q <= '0;
      small_q   <= '0;
      swap_q    <= 1'b0;
      error_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            exp_q     <= big_exp_d;
            man_big_q <= big_man_d;
            swap_q    <= swap_d;
            error_q   <= code_err_d;
            if (code_err_d || dist_d == '0) begin
              small_q <= small_init_d;
              state_q <= DONE;
              valid_q <= 1'b1;
            end else if (short_d) begin
              small_q <= small_short_d;
              state_q <= DONE;
              valid_q <= 1'b1;
            end else begin
              small_q <= small_init_d;
              cnt_q   <= dist_d;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          small_q <= {1'b0, small_q[W-1:2], small_q[1] | small_q[0]};
          cnt_q   <= cnt_q - EXP_SIZE'(1);
          if (cnt_q == EXP_SIZE'(1)) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o      = (state_q == IDLE);
  assign out_valid_o     = valid_q;
  assign out_exp_o       = exp_q;
  assign out_man_big_o   = man_big_q;
  assign out_man_small_o = small_q;
  assign out_swap_o      = swap_q;
  assign out_error_o     = error_q;

endmodule

// File: tb/tb_exp_align.sv
// Directed bench for exp_align: hand-computed alignment results, latencies,
// backpressure hold and reset during a shift.
module tb_exp_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_exp_a, in_exp_b;
  logic [23:0] in_man_a, in_man_b;
  logic [1:0]  in_code;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_exp;
  logic [23:0] out_man_big;
  logic [26:0] out_man_small;
  logic        out_swap;
  logic        out_error;

  int n_vec = 0;
  int n_err = 0;

  exp_align #(.EXP_SIZE(8), .MAN_SIZE(24)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_exp_a_i      (in_exp_a),
    .in_exp_b_i      (in_exp_b),
    .in_man_a_i      (in_man_a),
    .in_man_b_i      (in_man_b),
    .in_code_i       (in_code),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_exp_o       (out_exp),
    .out_man_big_o   (out_man_big),
    .out_man_small_o (out_man_small),
    .out_swap_o      (out_swap),
    .out_error_o     (out_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one operand set; lat is the number of edges from acceptance until out_valid is seen.
  task automatic do_op(input logic [7:0] ea, input logic [7:0] eb, input logic [23:0] ma,
                       input logic [23:0] mb, input logic [1:0] code, output int lat);
    in_exp_a = ea; in_exp_b = eb; in_man_a = ma; in_man_b = mb; in_code = code;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_res(input string tag, input int lat, input int exp_lat,
                           input logic [7:0] e_exp, input logic [23:0] e_big,
                           input logic [26:0] e_small, input logic e_swap, input logic e_err);
    chk({tag, ".lat"},   lat,           exp_lat);
    chk({tag, ".valid"}, out_valid,     1);
    chk({tag, ".exp"},   out_exp,       e_exp);
    chk({tag, ".big"},   out_man_big,   e_big);
    chk({tag, ".small"}, out_man_small, e_small);
    chk({tag, ".swap"},  out_swap,      e_swap);
    chk({tag, ".err"},   out_error,     e_err);
    chk({tag, ".rdy"},   in_ready,      0);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".idle_rdy"},   in_ready,  1);
    chk({tag, ".idle_valid"}, out_valid, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, out_valid,     0);
    chk({tag, ".rdy"},   in_ready,      1);
    chk({tag, ".exp"},   out_exp,       0);
    chk({tag, ".big"},   out_man_big,   0);
    chk({tag, ".small"}, out_man_small, 0);
    chk({tag, ".swap"},  out_swap,      0);
    chk({tag, ".err"},   out_error,     0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_exp_a = '0; in_exp_b = '0; in_man_a = '0; in_man_b = '0; in_code = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("reset");

    do_op(8'h80, 8'h7D, 24'hABCDEF, 24'hC00000, 2'b10, lat);
    check_res("d3", lat, 4, 8'h80, 24'hABCDEF, 27'h0C00000, 1'b0, 1'b0);
    release_out("d3");

    do_op(8'h10, 8'h14, 24'h800001, 24'h923456, 2'b01, lat);
    check_res("d4swap", lat, 5, 8'h14, 24'h923456, 27'h0400001, 1'b1, 1'b0);
    release_out("d4swap");

    do_op(8'h60, 8'h38, 24'h800000, 24'h000100, 2'b10, lat);
    check_res("short", lat, 1, 8'h60, 24'h800000, 27'h0000001, 1'b0, 1'b0);
    release_out("short");

    do_op(8'h60, 8'h38, 24'h800000, 24'h000000, 2'b10, lat);
    check_res("short0", lat, 1, 8'h60, 24'h800000, 27'h0000000, 1'b0, 1'b0);
    release_out("short0");

    do_op(8'h99, 8'h80, 24'h812345, 24'hFFFFFF, 2'b10, lat);
    check_res("d25", lat, 26, 8'h99, 24'h812345, 27'h0000003, 1'b0, 1'b0);
    release_out("d25");

    do_op(8'h9A, 8'h80, 24'h812345, 24'hFFFFFF, 2'b10, lat);
    check_res("d26", lat, 1, 8'h9A, 24'h812345, 27'h0000001, 1'b0, 1'b0);
    release_out("d26");

    do_op(8'h7F, 8'h7F, 24'h876543, 24'h555555, 2'b00, lat);
    check_res("d0", lat, 1, 8'h7F, 24'h876543, 27'h2AAAAA8, 1'b0, 1'b0);
    release_out("d0");

    do_op(8'h40, 8'h30, 24'h111111, 24'h222222, 2'b11, lat);
    check_res("err11", lat, 1, 8'h40, 24'h111111, 27'h1111110, 1'b0, 1'b1);
    release_out("err11");

    do_op(8'h05, 8'h06, 24'h333333, 24'h444444, 2'b00, lat);
    check_res("err00", lat, 1, 8'h05, 24'h333333, 27'h2222220, 1'b0, 1'b1);
    release_out("err00");

    do_op(8'h20, 8'h30, 24'h666666, 24'h777777, 2'b10, lat);
    check_res("err10", lat, 1, 8'h20, 24'h666666, 27'h3BBBBB8, 1'b0, 1'b1);
    release_out("err10");

    // Backpressure: hold DONE for 10 cycles while poking in_valid with unrelated operands.
    do_op(8'h80, 8'h7D, 24'hABCDEF, 24'hC00000, 2'b10, lat);
    check_res("bp", lat, 4, 8'h80, 24'hABCDEF, 27'h0C00000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_exp_a = 8'h01; in_exp_b = 8'h01; in_code = 2'b00;
      in_man_a = 24'h0F0F0F; in_man_b = 24'h0F0F0F;
      @(posedge clk); #1;
      chk("bp.rdy",   in_ready,      0);
      chk("bp.valid", out_valid,     1);
      chk("bp.small", out_man_small, 27'h0C00000);
      chk("bp.exp",   out_exp,       8'h80);
    end
    in_valid = 1'b0;
    release_out("bp");

    // Reset while shifting a d = 20 operand.
    in_exp_a = 8'h94; in_exp_b = 8'h80; in_code = 2'b10;
    in_man_a = 24'hFEDCBA; in_man_b = 24'h123456;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst.busy_valid", out_valid, 0);
    chk("midrst.busy_rdy",   in_ready,  0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero("midrst");

    do_op(8'h42, 8'h42, 24'h800000, 24'h900000, 2'b00, lat);
    check_res("post_rst", lat, 1, 8'h42, 24'h800000, 27'h4800000, 1'b0, 1'b0);
    release_out("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
